// File: rtl/simple_bus_engine.sv
// simple_bus_engine: queues bus commands in a small FIFO and executes them one
// at a time as multi-beat valid/ready transfers, pulsing done per command.
module simple_bus_engine #(
    parameter int CMD_W  = 4,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     en,
    output logic                     ready,
    input  logic [CMD_W-1:0]         cmd,
    input  logic [ADDR_W-1:0]        saddr,
    input  logic [ADDR_W-1:0]        daddr,
    input  logic [LEN_W-1:0]         len,
    input  logic                     abort,
    output logic                     bus_valid,
    input  logic                     bus_ready,
    output logic [CMD_W-1:0]         bus_cmd,
    output logic [ADDR_W-1:0]        bus_saddr,
    output logic [ADDR_W-1:0]        bus_daddr,
    output logic                     done,
    output logic [CMD_W-1:0]         done_cmd,
    output logic                     done_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Command FIFO storage and bookkeeping
    logic [CMD_W-1:0]  mem_cmd   [DEPTH];
    logic [ADDR_W-1:0] mem_saddr [DEPTH];
    logic [ADDR_W-1:0] mem_daddr [DEPTH];
    logic [LEN_W-1:0]  mem_len   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Working registers of the command in execution
    state_t            state;
    state_t            state_nxt;
    logic [CMD_W-1:0]  cmd_r;
    logic [ADDR_W-1:0] saddr_r;
    logic [ADDR_W-1:0] daddr_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  beat;
    logic              err_r;

    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = en && !full;
    assign pop   = (state == S_IDLE) && !empty;

    assign ready = !full;
    assign level = count;
    assign busy  = (state != S_IDLE) || !empty;

    // FIFO payload write; the array holds no state that matters before a push
    // NOTE: storage arrays are deliberately left out of reset -- the pointers and count decide validity, and a reset on RAM blocks inhibits memory inference.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_cmd[wr_ptr]   <= cmd;
            mem_saddr[wr_ptr] <= saddr;
            mem_daddr[wr_ptr] <= daddr;
            mem_len[wr_ptr]   <= len;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the level
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state: NOPs skip RUN, abort or last accepted beat ends RUN
    // NOTE: a default assignment ahead of the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (!empty) state_nxt = (mem_cmd[rd_ptr] != '0) ? S_RUN : S_DONE;
            S_RUN:  if (abort || (bus_ready && beat == len_r)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Working registers: load on pop, advance beat on handshake, clear in DONE
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cmd_r   <= '0;
            saddr_r <= '0;
            daddr_r <= '0;
            len_r   <= '0;
            beat    <= '0;
            err_r   <= 1'b0;
        end else if (pop) begin
            cmd_r   <= mem_cmd[rd_ptr];
            saddr_r <= mem_saddr[rd_ptr];
            daddr_r <= mem_daddr[rd_ptr];
            len_r   <= mem_len[rd_ptr];
            beat    <= '0;
            err_r   <= 1'b0;
        end else if (state == S_RUN) begin
            if (abort)
                err_r <= 1'b1;
            else if (bus_ready && beat != len_r)
                beat <= beat + 1'b1;
        end else if (state == S_DONE) begin
            beat  <= '0;
            err_r <= 1'b0;
        end
    end

    // FSM outputs: bus beat while RUN, completion pulse while DONE, else zero
    always_comb begin
        bus_valid = 1'b0;
        bus_cmd   = '0;
        bus_saddr = '0;
        bus_daddr = '0;
        done      = 1'b0;
        done_cmd  = '0;
        done_err  = 1'b0;
        if (state == S_RUN) begin
            bus_valid = 1'b1;
            bus_cmd   = cmd_r;
            bus_saddr = saddr_r + ADDR_W'(beat);
            bus_daddr = daddr_r + ADDR_W'(beat);
        end
        if (state == S_DONE) begin
            done     = 1'b1;
            done_cmd = cmd_r;
            done_err = err_r;
        end
    end

endmodule

// File: tb/tb_simple_bus_engine.sv
// tb_simple_bus_engine: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of the command engine.
module tb_simple_bus_engine;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 4;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_ = 1'b1;
    logic              en = 1'b0;
    logic              ready;
    logic [CMD_W-1:0]  cmd = '0;
    logic [ADDR_W-1:0] saddr = '0;
    logic [ADDR_W-1:0] daddr = '0;
    logic [LEN_W-1:0]  len = '0;
    logic              abort = 1'b0;
    logic              bus_valid;
    logic              bus_ready = 1'b0;
    logic [CMD_W-1:0]  bus_cmd;
    logic [ADDR_W-1:0] bus_saddr;
    logic [ADDR_W-1:0] bus_daddr;
    logic              done;
    logic [CMD_W-1:0]  done_cmd;
    logic              done_err;
    logic              busy;
    logic [2:0]        level;

    simple_bus_engine #(
        .CMD_W(CMD_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_(rst_), .en(en), .ready(ready), .cmd(cmd),
        .saddr(saddr), .daddr(daddr), .len(len), .abort(abort),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_cmd(bus_cmd),
        .bus_saddr(bus_saddr), .bus_daddr(bus_daddr), .done(done),
        .done_cmd(done_cmd), .done_err(done_err), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [15:0] saddr;
        logic [15:0] daddr;
        logic [3:0]  len;
    } cmd_t;

    typedef struct {
        logic [3:0] cmd;
        logic       err;
        int         beats;
        int         cyc;
    } done_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: queued commands, command in flight, beats transferred
    cmd_t  mq[$];
    cmd_t  cur;
    bit    m_run, m_done, m_err;
    logic [3:0] m_done_cmd;
    int    m_idx;
    int    m_done_cnt = 0;

    // observed completions
    done_t       log_q[$];
    int          mon_beats;
    logic [15:0] cur_addrs[$];
    logic [15:0] last_addrs[$];

    int br_mode = 0;
    int tg = 0;

    task automatic model_clear();
        mq.delete();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_idx  = 0;
        mon_beats = 0;
        cur_addrs.delete();
    endtask

    task automatic model_finish(input bit e);
        m_run      = 1'b0;
        m_done     = 1'b1;
        m_err      = e;
        m_done_cmd = cur.cmd;
        m_done_cnt++;
    endtask

    // one clock of the abstract engine, using the inputs seen this cycle
    task automatic model_step();
        int sz;
        sz = mq.size();
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_run) begin
            if (bus_ready) m_idx++;
            if (abort) model_finish(1'b1);
            else if (bus_ready && m_idx == int'(cur.len) + 1) model_finish(1'b0);
        end else if (sz > 0) begin
            cur   = mq.pop_front();
            m_idx = 0;
            if (cur.cmd == 4'd0) model_finish(1'b0);
            else m_run = 1'b1;
        end
        if (en && sz < DEPTH) mq.push_back('{cmd, saddr, daddr, len});
    endtask

    task automatic drive_ready();
        case (br_mode)
            0: bus_ready = 1'b0;
            1: bus_ready = 1'b1;
            2: bus_ready = 1'($urandom_range(0, 1));
            default: begin
                bus_ready = (tg % 3 == 0);
                tg++;
            end
        endcase
    endtask

    task automatic set_mode(input int m);
        br_mode = m;
        tg = 0;
        drive_ready();
    endtask

    // compare at the falling edge, advance model, cross the rising edge
    task automatic tick();
        logic [15:0] exp_s, exp_d;
        bit          exp_busy;
        @(negedge clk);
        if (!rst_) model_clear();
        total++;
        if (bus_valid !== m_run) begin
            bad++;
            $display("FAIL bus_valid cyc=%0d: got %b want %b", cyc, bus_valid, m_run);
        end
        if (m_run) begin
            exp_s = cur.saddr + 16'(m_idx);
            exp_d = cur.daddr + 16'(m_idx);
            total++;
            if ({bus_cmd, bus_saddr, bus_daddr} !== {cur.cmd, exp_s, exp_d}) begin
                bad++;
                $display("FAIL bus_beat cyc=%0d: got cmd=%h s=%h d=%h want cmd=%h s=%h d=%h",
                         cyc, bus_cmd, bus_saddr, bus_daddr, cur.cmd, exp_s, exp_d);
            end
        end
        total++;
        if (done !== m_done) begin
            bad++;
            $display("FAIL done cyc=%0d: got %b want %b", cyc, done, m_done);
        end
        if (m_done) begin
            total++;
            if ({done_cmd, done_err} !== {m_done_cmd, m_err}) begin
                bad++;
                $display("FAIL done_info cyc=%0d: got cmd=%h err=%b want cmd=%h err=%b",
                         cyc, done_cmd, done_err, m_done_cmd, m_err);
            end
        end
        exp_busy = m_run || m_done || (mq.size() != 0);
        total++;
        if ({level, ready, busy} !== {3'(mq.size()), 1'(mq.size() < DEPTH), exp_busy}) begin
            bad++;
            $display("FAIL fifo_status cyc=%0d: got level=%0d ready=%b busy=%b want level=%0d ready=%b busy=%b",
                     cyc, level, ready, busy, mq.size(), mq.size() < DEPTH, exp_busy);
        end
        if (rst_) begin
            if (bus_valid === 1'b1 && bus_ready) begin
                mon_beats++;
                cur_addrs.push_back(bus_saddr);
            end
            if (done === 1'b1) begin
                log_q.push_back('{done_cmd, done_err, mon_beats, cyc});
                last_addrs = cur_addrs;
                cur_addrs.delete();
                mon_beats = 0;
            end
            model_step();
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_ready();
    endtask

    task automatic push(input logic [3:0] c, input logic [15:0] s,
                        input logic [15:0] d, input logic [3:0] l);
        en = 1'b1; cmd = c; saddr = s; daddr = d; len = l;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, want 0", tag, busy, max);
        end
        tick();
    endtask

    task automatic test_reset();
        #1 rst_ = 1'b0;
        tick();
        tick();
        total++;
        if ({bus_valid, bus_cmd, bus_saddr, bus_daddr, done, done_cmd, done_err, busy, level, ready}
            !== {1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b done=%b busy=%b level=%0d ready=%b want 0,0,0,0,1",
                     bus_valid, done, busy, level, ready);
        end
        rst_ = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n0, e0;
        set_mode(1);
        n0 = log_q.size();
        push(4'd3, 16'h0100, 16'h2000, 4'd3);
        e0 = cyc;
        wait_idle(50, "single");
        total++;
        if (log_q.size() != n0 + 1) begin
            bad++;
            $display("FAIL single_count: got %0d dones want 1", log_q.size() - n0);
        end else begin
            total++;
            if ({log_q[n0].cmd, log_q[n0].err} !== {4'd3, 1'b0} || log_q[n0].beats != 4) begin
                bad++;
                $display("FAIL single_done: got cmd=%h err=%b beats=%0d want 3,0,4",
                         log_q[n0].cmd, log_q[n0].err, log_q[n0].beats);
            end
            total++;
            if (log_q[n0].cyc != e0 + 5) begin
                bad++;
                $display("FAIL single_latency: got done at edge %0d want %0d", log_q[n0].cyc, e0 + 5);
            end
        end
        total++;
        if (last_addrs.size() != 4 || last_addrs[0] !== 16'h0100 || last_addrs[3] !== 16'h0103) begin
            bad++;
            $display("FAIL single_addrs: got %0d beats want 0100..0103", last_addrs.size());
        end
    endtask

    task automatic test_backpressure();
        int n0;
        set_mode(3);
        n0 = log_q.size();
        push(4'd3, 16'h0100, 16'h2000, 4'd3);
        wait_idle(80, "bp");
        total++;
        if (log_q.size() != n0 + 1 || log_q[log_q.size()-1].beats != 4 || log_q[log_q.size()-1].err !== 1'b0) begin
            bad++;
            $display("FAIL bp_done: got %0d dones, last beats=%0d want 1 done with 4 beats",
                     log_q.size() - n0, mon_beats);
        end
    endtask

    task automatic test_fifo_full();
        int n0;
        set_mode(0);
        n0 = log_q.size();
        for (int i = 0; i < 5; i++)
            push(4'(i + 1), 16'(i * 16), 16'(16'h8000 + i * 16), 4'd1);
        total++;
        if ({ready, level} !== {1'b0, 3'd4}) begin
            bad++;
            $display("FAIL full_after5: got ready=%b level=%0d want 0,4", ready, level);
        end
        push(4'd9, 16'h9999, 16'h9999, 4'd1);
        total++;
        if (level !== 3'd4) begin
            bad++;
            $display("FAIL full_ignored: got level=%0d want 4", level);
        end
        set_mode(1);
        wait_idle(200, "full");
        total++;
        if (log_q.size() != n0 + 5) begin
            bad++;
            $display("FAIL full_count: got %0d dones want 5", log_q.size() - n0);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (log_q[n0 + i].cmd !== 4'(i + 1) || log_q[n0 + i].beats != 2) begin
                    bad++;
                    $display("FAIL full_order%0d: got cmd=%h beats=%0d want %0d,2",
                             i, log_q[n0 + i].cmd, log_q[n0 + i].beats, i + 1);
                end
            end
        end
    endtask

    task automatic test_wrap_nop();
        int n0;
        set_mode(1);
        push(4'd5, 16'hFFFE, 16'h0010, 4'd3);
        wait_idle(50, "wrap");
        total++;
        if (last_addrs.size() != 4 || last_addrs[0] !== 16'hFFFE || last_addrs[1] !== 16'hFFFF ||
            last_addrs[2] !== 16'h0000 || last_addrs[3] !== 16'h0001) begin
            bad++;
            $display("FAIL wrap_addrs: got %0d beats, want FFFE,FFFF,0000,0001", last_addrs.size());
        end
        n0 = log_q.size();
        push(4'd0, 16'h1234, 16'h5678, 4'd2);
        wait_idle(20, "nop");
        total++;
        if (log_q.size() != n0 + 1 || log_q[n0].cmd !== 4'd0 || log_q[n0].beats != 0 || log_q[n0].err !== 1'b0) begin
            bad++;
            $display("FAIL nop_done: got %0d dones want 1 with cmd=0 and 0 beats", log_q.size() - n0);
        end
    endtask

    task automatic test_abort();
        int  n0;
        bit  hit = 1'b0;
        set_mode(1);
        n0 = log_q.size();
        push(4'd7, 16'h0300, 16'h4000, 4'd15);
        push(4'd2, 16'h0500, 16'h6000, 4'd1);
        for (int i = 0; i < 40 && !hit; i++) begin
            if (bus_valid === 1'b1 && bus_saddr === 16'h0302) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                hit = 1'b1;
            end else begin
                tick();
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL abort_third_beat: got no third beat want beat at 0302");
        end
        wait_idle(60, "abort");
        total++;
        if (log_q.size() != n0 + 2) begin
            bad++;
            $display("FAIL abort_count: got %0d dones want 2", log_q.size() - n0);
        end else begin
            total++;
            if ({log_q[n0].cmd, log_q[n0].err} !== {4'd7, 1'b1} || log_q[n0].beats != 3) begin
                bad++;
                $display("FAIL abort_done: got cmd=%h err=%b beats=%0d want 7,1,3",
                         log_q[n0].cmd, log_q[n0].err, log_q[n0].beats);
            end
            total++;
            if ({log_q[n0+1].cmd, log_q[n0+1].err} !== {4'd2, 1'b0} || log_q[n0+1].beats != 2) begin
                bad++;
                $display("FAIL abort_next: got cmd=%h err=%b beats=%0d want 2,0,2",
                         log_q[n0+1].cmd, log_q[n0+1].err, log_q[n0+1].beats);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n0;
        set_mode(0);
        for (int i = 0; i < 3; i++)
            push(4'(i + 1), 16'(16'h0700 + i), 16'h0A00, 4'd5);
        total++;
        if (level !== 3'd2 || bus_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrun_setup: got level=%0d valid=%b want 2,1", level, bus_valid);
        end
        rst_ = 1'b0;
        #1;
        total++;
        if ({bus_valid, done, level, ready, busy} !== {1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL midrun_reset: got valid=%b done=%b level=%0d ready=%b busy=%b want 0,0,0,1,0",
                     bus_valid, done, level, ready, busy);
        end
        tick();
        tick();
        rst_ = 1'b1;
        set_mode(1);
        n0 = log_q.size();
        repeat (12) tick();
        total++;
        if (log_q.size() != n0) begin
            bad++;
            $display("FAIL midrun_no_done: got %0d dones want 0", log_q.size() - n0);
        end
    endtask

    task automatic test_random();
        int n0, c0;
        set_mode(2);
        n0 = log_q.size();
        c0 = m_done_cnt;
        for (int i = 0; i < 400; i++) begin
            en    = 1'($urandom_range(0, 1));
            cmd   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            saddr = 16'($urandom);
            daddr = 16'($urandom);
            len   = 4'($urandom_range(0, 7));
            abort = ($urandom_range(0, 15) == 0);
            tick();
        end
        en = 1'b0;
        abort = 1'b0;
        set_mode(1);
        wait_idle(300, "random");
        total++;
        if (log_q.size() - n0 != m_done_cnt - c0 || m_done_cnt == c0) begin
            bad++;
            $display("FAIL random_dones: got %0d want %0d", log_q.size() - n0, m_done_cnt - c0);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_backpressure();
        test_fifo_full();
        test_wrap_nop();
        test_abort();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
